// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a small first-word-fall-through
// byte FIFO. Exposes the head byte, a non-empty flag and sticky
// overrun / framing error flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low level on the synchronised rx
// S_START | counting to mid start bit to confirm it is not a glitch
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | sampling the stop bit; push on high, framing error on low
// S_BREAK | line held low after a bad stop bit; wait for it to go high
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int ClkPerBit = 868,
    parameter int Depth     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       pop,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(ClkPerBit);
    localparam int PW = $clog2(Depth);
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(ClkPerBit / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(ClkPerBit - 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(Depth);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, frame_set;

    logic [7:0]    mem [Depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic          do_push, do_pop, full, ovr_set;

    // Two-flop synchroniser for the asynchronous rx line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver next-state: bit timing, sampling and frame completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot for a same-cycle push when full.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        full    = (count_q == DEPTH_N);
        do_push = push && (!full || do_pop);
        ovr_set = push && full && !do_pop;

        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        overrun_d   = ovr_set   | (overrun_q   & ~clr_err);
        frame_err_d = frame_set | (frame_err_q & ~clr_err);
    end

    // Receiver and FIFO control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage array; contents need no reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign valid     = (count_q != '0);
    assign data      = valid ? mem[rd_ptr_q] : 8'h00;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with ClkPerBit = 16 and Depth = 4.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       pop;
    logic       clr_err;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx_fifo #(.ClkPerBit(CPB), .Depth(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .pop       (pop),
        .clr_err   (clr_err),
        .data      (data),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Callers are always #1 after a rising edge; each bit lasts CPB edges.
    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    // Leaves rx at the stop-bit level so a low stop can be extended into a break.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic pulse_pop;
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] exp_b;

        reset = 1'b1; rx = 1'b1; pop = 1'b0; clr_err = 1'b0;
        tick(3);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        tick(5);

        // Basic receive with latency measurement from the start edge.
        n = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!valid && n < 400) begin
                    tick(1);
                    n++;
                end
            end
        join
        check_eq("basic_latency", n, 155);
        check_eq("basic_data", data, 8'hA5);
        pulse_pop;
        check_eq("basic_valid_after_pop", valid, 0);
        tick(10);

        // Overrun: five back-to-back frames into a 4-entry FIFO.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check_eq("ovr_not_yet", overrun, 0);
        send_frame(8'h05, 1'b1);
        check_eq("ovr_set", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            check_eq("ovr_read", data, exp_b);
            pulse_pop;
        end
        check_eq("ovr_empty", valid, 0);
        check_eq("ovr_sticky", overrun, 1);
        pulse_clr;
        check_eq("ovr_cleared", overrun, 0);
        tick(10);

        // Framing error followed by a long break.
        send_frame(8'h3C, 1'b0);
        tick(50 * CPB);
        check_eq("ferr_set", frame_err, 1);
        check_eq("ferr_no_frames", valid, 0);
        rx = 1'b1;
        tick(20);
        send_frame(8'h7E, 1'b1);
        check_eq("ferr_next_valid", valid, 1);
        check_eq("ferr_next_data", data, 8'h7E);
        check_eq("ferr_sticky", frame_err, 1);
        pulse_pop;
        pulse_clr;
        check_eq("ferr_cleared", frame_err, 0);
        tick(10);

        // Glitch rejection.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        check_eq("glitch_valid", valid, 0);
        check_eq("glitch_ferr", frame_err, 0);
        send_frame(8'h55, 1'b1);
        check_eq("glitch_next_data", data, 8'h55);
        pulse_pop;
        check_eq("glitch_empty", valid, 0);
        tick(10);

        // Full FIFO with pop on the same edge as the push.
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        check_eq("full_head", data, 8'h10);
        fork
            send_frame(8'h14, 1'b1);
            begin
                tick(154);
                pop = 1'b1;
                tick(1);
                pop = 1'b0;
            end
        join
        check_eq("full_no_overrun", overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'h10 + 8'(i);
            check_eq("full_read", data, exp_b);
            pulse_pop;
        end
        check_eq("full_empty", valid, 0);
        tick(10);

        // Reset during data bit 3 with a byte queued.
        send_frame(8'h99, 1'b1);
        check_eq("mrst_queued", data, 8'h99);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                tick(70);
                check_eq("mrst_pre_valid", valid, 1);
                reset = 1'b1;
                #1;
                check_eq("mrst_valid", valid, 0);
                check_eq("mrst_data", data, 0);
                check_eq("mrst_overrun", overrun, 0);
                check_eq("mrst_ferr", frame_err, 0);
                tick(20);
                reset = 1'b0;
            end
        join
        rx = 1'b1;
        tick(20);
        check_eq("mrst_idle_empty", valid, 0);
        send_frame(8'h42, 1'b1);
        check_eq("mrst_after_valid", valid, 1);
        check_eq("mrst_after_data", data, 8'h42);
        check_eq("mrst_after_ferr", frame_err, 0);
        pulse_pop;
        check_eq("mrst_after_empty", valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
